// File: rtl/seq_alu.sv
// Handshaked ALU with iterative shift-add multiply and restoring divide.
// Define SEQ_ALU_FAST_MUL_EN to replace the iterative multiplier with a single-cycle one.
module seq_alu #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      ALU_ctr,
  input  logic [XLEN-1:0] ALU_srcA,
  input  logic [XLEN-1:0] ALU_srcB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALU_resp,
  output logic            zero,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  localparam logic [4:0] OpAdd    = 5'd0;
  localparam logic [4:0] OpSub    = 5'd1;
  localparam logic [4:0] OpAnd    = 5'd2;
  localparam logic [4:0] OpOr     = 5'd3;
  localparam logic [4:0] OpXor    = 5'd4;
  localparam logic [4:0] OpSll    = 5'd5;
  localparam logic [4:0] OpSrl    = 5'd6;
  localparam logic [4:0] OpSlt    = 5'd7;
  localparam logic [4:0] OpSra    = 5'd8;
  localparam logic [4:0] OpSltu   = 5'd9;
  localparam logic [4:0] OpMul    = 5'd10;
  localparam logic [4:0] OpMulh   = 5'd11;
  localparam logic [4:0] OpMulhsu = 5'd12;
  localparam logic [4:0] OpMulhu  = 5'd13;
  localparam logic [4:0] OpDiv    = 5'd14;
  localparam logic [4:0] OpDivu   = 5'd15;
  localparam logic [4:0] OpRem    = 5'd16;
  localparam logic [4:0] OpRemu   = 5'd17;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e              state_q, state_d;
  logic [4:0]          op_q, op_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic                neg_q, neg_d, rneg_q, rneg_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]     resp_q, resp_d;
  logic                zero_q, zero_d;

  logic [SHAMT_W-1:0]  shamt;
  logic                a_sgn, b_sgn, div_by_zero, div_ovf;
  logic [XLEN-1:0]     a_mag, b_mag, simple_res;
  logic [XLEN:0]       mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0]   mul_nx, div_nx, prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix;

  assign shamt       = ALU_srcB[SHAMT_W-1:0];
  assign a_sgn       = ALU_srcA[XLEN-1] && (ALU_ctr inside {OpMulh, OpMulhsu, OpDiv, OpRem});
  assign b_sgn       = ALU_srcB[XLEN-1] && (ALU_ctr inside {OpMulh, OpDiv, OpRem});
  assign a_mag       = a_sgn ? -ALU_srcA : ALU_srcA;
  assign b_mag       = b_sgn ? -ALU_srcB : ALU_srcB;
  assign div_by_zero = (ALU_srcB == '0);
  assign div_ovf     = (ALU_ctr inside {OpDiv, OpRem}) && &ALU_srcB &&
                       (ALU_srcA == {1'b1, {(XLEN-1){1'b0}}});

  always_comb begin
    simple_res = '0;
    case (ALU_ctr)
      OpAdd:   simple_res = ALU_srcA + ALU_srcB;
      OpSub:   simple_res = ALU_srcA - ALU_srcB;
      OpAnd:   simple_res = ALU_srcA & ALU_srcB;
      OpOr:    simple_res = ALU_srcA | ALU_srcB;
      OpXor:   simple_res = ALU_srcA ^ ALU_srcB;
      OpSll:   simple_res = ALU_srcA << shamt;
      OpSrl:   simple_res = ALU_srcA >> shamt;
      OpSlt:   simple_res = {{(XLEN-1){1'b0}}, $signed(ALU_srcA) < $signed(ALU_srcB)};
      OpSra:   simple_res = $unsigned($signed(ALU_srcA) >>> shamt);
      OpSltu:  simple_res = {{(XLEN-1){1'b0}}, ALU_srcA < ALU_srcB};
      default: simple_res = '0;
    endcase
  end

  // acc holds {partial product high, remaining multiplier bits}; shifts right each step.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_nx   = {mul_sum, acc_q[XLEN-1:1]};
  assign prod_fix = neg_q ? -mul_nx : mul_nx;

  // acc holds {partial remainder, dividend/quotient}; quotient bits shift in from the right.
  assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_nx   = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign quo_fix  = neg_q  ? -div_nx[XLEN-1:0]      : div_nx[XLEN-1:0];
  assign rem_fix  = rneg_q ? -div_nx[2*XLEN-1:XLEN] : div_nx[2*XLEN-1:XLEN];

`ifdef SEQ_ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
  assign ext_a     = {{XLEN{ALU_srcA[XLEN-1] && (ALU_ctr inside {OpMulh, OpMulhsu})}}, ALU_srcA};
  assign ext_b     = {{XLEN{ALU_srcB[XLEN-1] && (ALU_ctr == OpMulh)}}, ALU_srcB};
  assign fast_prod = ext_a * ext_b;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = ALU_ctr;
          state_d = StDone;
          if (ALU_ctr inside {[OpMul:OpMulhu]}) begin
`ifdef SEQ_ALU_FAST_MUL_EN
            resp_d = (ALU_ctr == OpMul) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
            acc_d   = {{XLEN{1'b0}}, b_mag};
            opnd_d  = a_mag;
            neg_d   = a_sgn ^ b_sgn;
            cnt_d   = '0;
            state_d = StMul;
`endif
          end else if (ALU_ctr inside {[OpDiv:OpRemu]}) begin
            if (div_by_zero) begin
              resp_d = (ALU_ctr inside {OpDiv, OpDivu}) ? '1 : ALU_srcA;
            end else if (div_ovf) begin
              resp_d = (ALU_ctr == OpDiv) ? ALU_srcA : '0;
            end else begin
              acc_d   = {{XLEN{1'b0}}, a_mag};
              opnd_d  = b_mag;
              neg_d   = a_sgn ^ b_sgn;
              rneg_d  = a_sgn;
              cnt_d   = '0;
              state_d = StDiv;
            end
          end else begin
            resp_d = simple_res;
          end
        end
      end
      StMul: begin
        acc_d = mul_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) begin
          resp_d  = (op_q == OpMul) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
          state_d = StDone;
        end
      end
      StDiv: begin
        acc_d = div_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) begin
          resp_d  = (op_q inside {OpDiv, OpDivu}) ? quo_fix : rem_fix;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    zero_d = (resp_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      resp_q  <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StMul) || (state_q == StDiv);
  assign ALU_resp  = resp_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases, random ops against an arithmetic model,
// backpressure and reset while a divide is in flight.
module tb_seq_alu;

  localparam int unsigned XLEN = 32;
`ifdef SEQ_ALU_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = XLEN + 1;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      ALU_ctr;
  logic [XLEN-1:0] ALU_srcA;
  logic [XLEN-1:0] ALU_srcB;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ALU_resp;
  logic            zero;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ALU_ctr  (ALU_ctr),
    .ALU_srcA (ALU_srcA),
    .ALU_srcB (ALU_srcB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALU_resp (ALU_resp),
    .zero     (zero),
    .busy     (busy)
  );

  // Reference result from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    logic        ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = 32'h0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = a << b[4:0];
      5'd6:  r = a >> b[4:0];
      5'd7:  r = {31'b0, sa < sb};
      5'd8:  r = $signed(a) >>> b[4:0];
      5'd9:  r = {31'b0, a < b};
      5'd10: begin p = sa * sb; r = p[31:0];  end
      5'd11: begin p = sa * sb; r = p[63:32]; end
      5'd12: begin p = sa * ub; r = p[63:32]; end
      5'd13: begin p = ua * ub; r = p[63:32]; end
      5'd14: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      5'd15: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 0) r = a;
        else if (ovf) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      5'd17: r = (b == 0) ? a : a % b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, b);
    if (op >= 5'd10 && op <= 5'd13) return MulLat;
    if (op >= 5'd14 && op <= 5'd17) begin
      if (b == 0) return 1;
      if ((op == 5'd14 || op == 5'd16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
    end
    return 1;
  endfunction

  // Issues one request, waits (bounded) for the result, then completes the handshake.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, b,
                        output logic [31:0] resp, output logic zr, output int lat,
                        output logic bsy);
    @(negedge clk);
    in_valid  = 1'b1;
    ALU_ctr   = op;
    ALU_srcA  = a;
    ALU_srcB  = b;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ALU_ctr  = 5'($urandom);
    ALU_srcA = $urandom;
    ALU_srcB = $urandom;
    lat = 1;
    @(negedge clk);
    bsy = busy;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    resp = ALU_resp;
    zr   = zero;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ALU_ctr   = '0;
    ALU_srcA  = '0;
    ALU_srcB  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, in_ready, zero} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_flags: got ov/busy/rdy/zero=%b, want 0011",
               {out_valid, busy, in_ready, zero});
    end
    checks++;
    if (ALU_resp !== 32'h0) begin
      errors++;
      $display("FAIL reset_resp: got %h, want 00000000", ALU_resp);
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[14];
    logic [31:0] resp;
    logic        zr, bsy;
    int          lat, el;
    vecs = '{
      '{5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
      '{5'd8,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000},
      '{5'd11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
      '{5'd13, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001},
      '{5'd10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE},
      '{5'd14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
      '{5'd16, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
      '{5'd15, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF},
      '{5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
      '{5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{5'd25, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000},
      '{5'd5,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000},
      '{5'd9,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001},
      '{5'd7,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000}
    };
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, resp, zr, lat, bsy);
      el = exp_lat(vecs[i].op, vecs[i].a, vecs[i].b);
      checks++;
      if (resp !== vecs[i].exp) begin
        errors++;
        $display("FAIL dir_resp[%0d] op=%0d: got %h, want %h", i, vecs[i].op, resp, vecs[i].exp);
      end
      checks++;
      if (zr !== (vecs[i].exp == 0)) begin
        errors++;
        $display("FAIL dir_zero[%0d]: got %b, want %b", i, zr, vecs[i].exp == 0);
      end
      checks++;
      if (lat != el) begin
        errors++;
        $display("FAIL dir_latency[%0d] op=%0d: got %0d, want %0d", i, vecs[i].op, lat, el);
      end
      checks++;
      if (bsy !== (el > 1)) begin
        errors++;
        $display("FAIL dir_busy[%0d]: got %b, want %b", i, bsy, el > 1);
      end
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [4:0]  op;
    logic [31:0] a, b, resp, exp;
    logic        zr, bsy;
    int          lat, el;
    for (int n = 0; n < 250; n++) begin
      op  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      a   = pick_operand();
      b   = pick_operand();
      run_op(op, a, b, resp, zr, lat, bsy);
      exp = model(op, a, b);
      el  = exp_lat(op, a, b);
      checks++;
      if (resp !== exp || zr !== (exp == 0) || lat != el) begin
        errors++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h: got resp=%h zero=%b lat=%0d, want %h %b %0d",
                 n, op, a, b, resp, zr, lat, exp, exp == 0, el);
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    in_valid  = 1'b1;
    ALU_ctr   = 5'd9;
    ALU_srcA  = 32'h0000_0001;
    ALU_srcB  = 32'hFFFF_FFFF;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    ALU_ctr  = 5'd0;
    ALU_srcA = 32'h5;
    ALU_srcB = 32'h6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || ALU_resp !== 32'h1 || in_ready !== 1'b0 || zero !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d]: got ov=%b resp=%h rdy=%b zero=%b, want 1 00000001 0 0",
                 i, out_valid, ALU_resp, in_ready, zero);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: got rdy=%b ov=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_div();
    int seen;
    @(negedge clk);
    in_valid = 1'b1;
    ALU_ctr  = 5'd14;
    ALU_srcA = 32'd100;
    ALU_srcB = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL middiv_busy: got %b, want 1", busy);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, in_ready, zero} !== 4'b0011 || ALU_resp !== 32'h0) begin
      errors++;
      $display("FAIL middiv_reset: got ov/busy/rdy/zero=%b resp=%h, want 0011 00000000",
               {out_valid, busy, in_ready, zero}, ALU_resp);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL middiv_discard: got %0d valid cycles, want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_div();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the core's combinational ALU.
- Keeps the existing 8 opcodes and their encodings, and adds SRA, SLTU and RV32M-style multiply/divide/remainder.
- Multiply and divide are iterative, multi-cycle operations.
- Sits between the decode/register-read stage and writeback; the control FSM stalls on in_ready/out_valid.

Parameters:
XLEN, 32, operand/result width (>=8, power of 2)
SHAMT_W, $clog2(XLEN), shift-amount bits taken from ALU_srcB LSBs

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state
in_valid  in  1  request present
in_ready  out  1  block can accept a request
ALU_ctr  in  5  operation code
ALU_srcA  in  XLEN  operand A
ALU_srcB  in  XLEN  operand B
out_valid  out  1  ALU_resp/zero valid
out_ready  in  1  consumer accepts result
ALU_resp  out  XLEN  registered result
zero  out  1  registered (ALU_resp == 0)
busy  out  1  iterative operation in progress

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT (signed), 8 SRA, 9 SLTU, 10 MUL (low XLEN), 11 MULH (s×s), 12 MULHSU (s×u), 13 MULHU (u×u), 14 DIV, 15 DIVU, 16 REM, 17 REMU. Codes 18-31 return 0 with single-cycle latency.
- All arithmetic wraps modulo 2^XLEN. Shift amount is ALU_srcB[SHAMT_W-1:0]. SLT/SLTU return 1 or 0 zero-extended.
- FSM states: IDLE, MUL, DIV, DONE.
- in_ready = (state==IDLE). A request is accepted on a clock edge where in_valid && in_ready; operands and op are captured on that edge.
- Single-cycle ops (0-9, illegal): result registered at acceptance, state goes to DONE. out_valid is high in the cycle after acceptance (latency 1).
- MUL group: shift-add over XLEN iterations, one per cycle. Signed operands are converted to magnitude and the 2*XLEN product sign is fixed at the end. Goes to DONE after XLEN cycles in MUL; out_valid rises XLEN+1 cycles after acceptance.
- DIV group: restoring, one quotient bit per cycle, XLEN cycles, then signs are corrected. Quotient sign = sign(A)^sign(B); remainder takes the sign of A. Same latency as MUL.
- Divide by zero: skips DIV, goes to DONE in 1 cycle. DIV/DIVU give all-ones; REM/REMU give A.
- Signed overflow (A = -2^(XLEN-1), B = -1): skips DIV, 1 cycle. DIV gives A; REM gives 0.
- DONE: out_valid=1. ALU_resp and zero are held stable until out_ready. On out_valid && out_ready the state returns to IDLE. No back-to-back acceptance in the same edge, so minimum throughput is one op per 2 cycles.
- busy=1 in MUL and DIV only.
- Iteration counter is $clog2(XLEN)+1 bits, reset to 0 on entry to MUL/DIV, and exits when it equals XLEN-1 at the edge.
- Reset (including mid-MUL/DIV or in DONE): state=IDLE, ALU_resp=0, zero=1, out_valid=0, busy=0, in_ready=1 in the cycle after reset deasserts. Any in-flight operation is discarded with no output.
- Inputs are ignored while in_ready=0. Operand changes after acceptance have no effect.

Optional Feature:
- Macro: SEQ_ALU_FAST_MUL_EN.
- Defined: opcodes 10-13 use a combinational 2*XLEN-bit multiplier and complete like single-cycle ops (latency 1, busy never set by MUL). State MUL is unreachable.
- Undefined: the iterative multiplier above is used (latency XLEN+1). DIV is unchanged in both cases.

Test Plan:
- Reset mid-DIV (op 14, A=100, B=7, reset at iteration 10) -> next cycle out_valid=0, busy=0, in_ready=1, ALU_resp=0, zero=1.
- ADD A=0xFFFFFFFF B=1, out_ready=1 -> out_valid 1 cycle later, ALU_resp=0, zero=1. SRA A=0x80000000 B=0x24 -> 0xF8000000.
- MULH A=0xFFFFFFFF(-1) B=0x00000002 -> 0xFFFFFFFF after 33 cycles (1 with SEQ_ALU_FAST_MUL_EN). MULHU with the same operands -> 0x00000001. MUL -> 0xFFFFFFFE.
- DIV A=-7 B=2 -> 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). DIVU A=7 B=0 -> 0xFFFFFFFF in 1 cycle. REM A=0x80000000 B=-1 -> 0.
- Backpressure: SLTU A=1 B=0xFFFFFFFF with out_ready=0 for 5 cycles -> out_valid held, ALU_resp=1 stable, in_ready=0 throughout, new in_valid ignored. out_ready=1 -> IDLE next cycle.
- Illegal op 25 -> ALU_resp=0, zero=1, latency 1. SLL A=1 B=0x3F -> 0x80000000 (XLEN=32).
